// File: rtl/stream_input.sv
// Serial-to-matrix loader: accepts signed elements over valid/ready and writes
// them row-major into the operand buffer, pulsing mRdy on the final element.
module stream_input #(
    parameter int maxWidthLen = 4,
    parameter int sizeValue   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [maxWidthLen-1:0] sizeX,
    input  logic [maxWidthLen-1:0] sizeY,
    input  logic                   inValid,
    input  logic [sizeValue-1:0]   in,
    output logic                   inRdy,
    output logic                   we,
    output logic [maxWidthLen-1:0] wx,
    output logic [maxWidthLen-1:0] wy,
    output logic [sizeValue-1:0]   wdata,
    output logic                   mRdy,
    output logic                   busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [maxWidthLen-1:0] IDX_ZERO = {maxWidthLen{1'b0}};
    localparam logic [maxWidthLen-1:0] IDX_ONE  = {{(maxWidthLen-1){1'b0}}, 1'b1};

    state_t                 state_r;
    state_t                 state_s;
    logic [maxWidthLen-1:0] sx_r;
    logic [maxWidthLen-1:0] sy_r;
    logic [maxWidthLen-1:0] cx_r;
    logic [maxWidthLen-1:0] cy_r;
    logic                   we_r;
    logic [maxWidthLen-1:0] wx_r;
    logic [maxWidthLen-1:0] wy_r;
    logic [sizeValue-1:0]   wdata_r;
    logic                   mrdy_r;
    logic                   rdy_s;
    logic                   accept_s;
    logic                   row_end_s;
    logic                   last_s;

    // Handshake decode: start always pre-empts an element offered the same cycle.
    always_comb begin
        rdy_s     = (state_r == LOAD);
        accept_s  = inValid & rdy_s & ~start;
        row_end_s = (cx_r == sx_r);
        last_s    = accept_s & row_end_s & (cy_r == sy_r);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (start) begin
                    state_s = LOAD;
                end else if (last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = LOAD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, latched sizes, counters and registered write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            sx_r    <= IDX_ZERO;
            sy_r    <= IDX_ZERO;
            cx_r    <= IDX_ZERO;
            cy_r    <= IDX_ZERO;
            we_r    <= 1'b0;
            wx_r    <= IDX_ZERO;
            wy_r    <= IDX_ZERO;
            wdata_r <= {sizeValue{1'b0}};
            mrdy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            we_r    <= accept_s;
            mrdy_r  <= last_s;
            if (accept_s) begin
                wx_r    <= cx_r;
                wy_r    <= cy_r;
                wdata_r <= in;
            end
            if (start) begin
                sx_r <= sizeX;
                sy_r <= sizeY;
                cx_r <= IDX_ZERO;
                cy_r <= IDX_ZERO;
            end else if (last_s) begin
                // Parking at zero keeps cy from ever stepping past sy.
                cx_r <= IDX_ZERO;
                cy_r <= IDX_ZERO;
            end else if (accept_s) begin
                if (row_end_s) begin
                    cx_r <= IDX_ZERO;
                    cy_r <= cy_r + IDX_ONE;
                end else begin
                    cx_r <= cx_r + IDX_ONE;
                end
            end
        end
    end

    assign inRdy = rdy_s;
    assign busy  = rdy_s;
    assign we    = we_r;
    assign wx    = wx_r;
    assign wy    = wy_r;
    assign wdata = wdata_r;
    assign mRdy  = mrdy_r;

endmodule

// File: tb/tb_stream_input.sv
// Directed and randomized bench for stream_input, checked cycle by cycle
// against an element-index reference model.
module tb_stream_input;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  sizeX;
    logic [3:0]  sizeY;
    logic        inValid;
    logic [15:0] in_d;
    logic        inRdy;
    logic        we;
    logic [3:0]  wx;
    logic [3:0]  wy;
    logic [15:0] wdata;
    logic        mRdy;
    logic        busy;

    stream_input #(.maxWidthLen(4), .sizeValue(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sizeX(sizeX), .sizeY(sizeY),
        .inValid(inValid), .in(in_d), .inRdy(inRdy), .we(we), .wx(wx),
        .wy(wy), .wdata(wdata), .mRdy(mRdy), .busy(busy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: a load is "element k of (sx+1)*(sy+1)"; address from k.
    bit          m_loading;
    int          m_sx, m_sy, m_k;
    logic        e_we, e_mrdy;
    logic [3:0]  e_wx, e_wy;
    logic [15:0] e_wdata;
    int          mrdy_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        chk("inRdy", {31'b0, inRdy}, {31'b0, m_loading});
        chk("busy", {31'b0, busy}, {31'b0, m_loading});
        chk("we", {31'b0, we}, {31'b0, e_we});
        chk("wx", {28'b0, wx}, {28'b0, e_wx});
        chk("wy", {28'b0, wy}, {28'b0, e_wy});
        chk("wdata", {16'b0, wdata}, {16'b0, e_wdata});
        chk("mRdy", {31'b0, mRdy}, {31'b0, e_mrdy});
    endtask

    // One clock: drive inputs, advance the model, compare #1 after the edge.
    task automatic cycle(input bit st, input bit vld, input logic [15:0] d);
        bit acc;
        start   = st;
        inValid = vld;
        in_d    = d;
        acc = m_loading && vld && !st;
        @(posedge clk);
        #1;
        e_mrdy = 1'b0;
        e_we   = acc;
        if (acc) begin
            e_wx    = 4'(m_k % (m_sx + 1));
            e_wy    = 4'(m_k / (m_sx + 1));
            e_wdata = d;
            m_k++;
            if (m_k == (m_sx + 1) * (m_sy + 1)) begin
                e_mrdy    = 1'b1;
                m_loading = 1'b0;
            end
        end
        if (st) begin
            m_loading = 1'b1;
            m_sx = int'(sizeX);
            m_sy = int'(sizeY);
            m_k  = 0;
        end
        if (mRdy === 1'b1) mrdy_seen++;
        check_outputs();
        start = 1'b0;
        // Size inputs must be ignored outside the start cycle.
        sizeX = 4'($urandom_range(0, 15));
        sizeY = 4'($urandom_range(0, 15));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        inValid = 1'b0;
        @(posedge clk);
        #1;
        m_loading = 1'b0;
        m_k = 0;
        e_we = 1'b0; e_mrdy = 1'b0;
        e_wx = 4'd0; e_wy = 4'd0; e_wdata = 16'd0;
        check_outputs();
        rst = 1'b1;
    endtask

    task automatic begin_load(input logic [3:0] x, input logic [3:0] y);
        sizeX = x;
        sizeY = y;
        mrdy_seen = 0;
        cycle(1'b1, 1'b0, 16'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; sizeX = 4'd0; sizeY = 4'd0;
        inValid = 1'b0; in_d = 16'd0;
        m_sx = 0; m_sy = 0; mrdy_seen = 0;
        #2;
        do_reset();
        do_reset();

        // Back-to-back 2x3 load of 10..15.
        begin_load(4'd1, 4'd2);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 16'(10 + i));
        cycle(1'b0, 1'b1, 16'd99);
        cycle(1'b0, 1'b0, 16'd0);
        chk("t1_mrdy_count", 32'(mrdy_seen), 32'd1);

        // Same load with inValid pattern 1,0,0.
        begin_load(4'd1, 4'd2);
        for (int i = 0; i < 18; i++) cycle(1'b0, (i % 3) == 0, 16'(10 + i / 3));
        cycle(1'b0, 1'b0, 16'd0);
        chk("t2_mrdy_count", 32'(mrdy_seen), 32'd1);

        // Single-element matrix, negative data.
        begin_load(4'd0, 4'd0);
        cycle(1'b0, 1'b1, 16'hFFFB);
        cycle(1'b0, 1'b1, 16'h1234);
        chk("t3_mrdy_count", 32'(mrdy_seen), 32'd1);
        chk("t3_wdata_neg5", {16'b0, wdata}, 32'h0000FFFB);

        // Elements offered while idle are dropped; start beats a valid element.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'd7);
        sizeX = 4'd2; sizeY = 4'd1; mrdy_seen = 0;
        cycle(1'b1, 1'b1, 16'd7);
        cycle(1'b0, 1'b1, 16'd7);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 16'(20 + i));
        chk("t4_mrdy_count", 32'(mrdy_seen), 32'd1);

        // Restart after 5 of 16 elements, then a full load.
        begin_load(4'd3, 4'd3);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'(100 + i));
        sizeX = 4'd3; sizeY = 4'd3;
        cycle(1'b1, 1'b1, 16'd555);
        chk("t5_no_mrdy_restart", 32'(mrdy_seen), 32'd0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 16'(200 + i));
        chk("t5_mrdy_count", 32'(mrdy_seen), 32'd1);

        // Reset at element 5 of a load.
        begin_load(4'd3, 4'd3);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'(300 + i));
        inValid = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'd9);
        chk("t5_no_mrdy_reset", 32'(mrdy_seen), 32'd0);

        // Full 16x16 load of random values with random gaps.
        begin_load(4'd15, 4'd15);
        for (int i = 0; i < 1500 && m_loading; i++)
            cycle(1'b0, $urandom_range(0, 3) != 0, 16'($urandom));
        chk("t6_done", {31'b0, m_loading}, 32'd0);
        chk("t6_last_wx", {28'b0, wx}, 32'd15);
        chk("t6_last_wy", {28'b0, wy}, 32'd15);
        chk("t6_mrdy_count", 32'(mrdy_seen), 32'd1);
        cycle(1'b0, 1'b1, 16'd1);

        // Random small loads with occasional restarts.
        for (int r = 0; r < 8; r++) begin
            begin_load(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            for (int i = 0; i < 400 && m_loading; i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    sizeX = 4'($urandom_range(0, 3));
                    sizeY = 4'($urandom_range(0, 3));
                    cycle(1'b1, $urandom_range(0, 1) != 0, 16'($urandom));
                end else begin
                    cycle(1'b0, $urandom_range(0, 2) != 0, 16'($urandom));
                end
            end
            chk("rand_done", {31'b0, m_loading}, 32'd0);
            cycle(1'b0, 1'b0, 16'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
